// File: rtl/segway_motion_monitor.sv
// Run-time monitor for the Segway balance/steering loop: after a settle interval it samples
// platform angle and wheel speeds over a window, then grades levelness and turn direction.
module segway_motion_monitor #(
  parameter int unsigned THETA_W       = 16,
  parameter int unsigned OMEGA_W       = 16,
  parameter int unsigned SETTLE_CYCLES = 700000,
  parameter int unsigned WIN_CYCLES    = 2000000,
  parameter int unsigned THETA_THRESH  = 300,
  parameter int unsigned TURN_MARGIN   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [1:0]                expect_dir,
  input  logic signed [THETA_W-1:0] theta_platform,
  input  logic signed [OMEGA_W-1:0] omega_lft,
  input  logic signed [OMEGA_W-1:0] omega_rght,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      theta_ok,
  output logic                      dir_ok,
  output logic [1:0]                dir_seen,
  output logic [THETA_W-2:0]        theta_max_abs,
  output logic [7:0]                fail_cnt
);

  localparam int unsigned MAG_W       = THETA_W - 1;
  localparam int unsigned DIFF_W      = OMEGA_W + 1;
  localparam int unsigned ACC_W       = OMEGA_W + 1 + $clog2(WIN_CYCLES + 1);
  localparam int unsigned CNT_MAX     = (SETTLE_CYCLES > WIN_CYCLES) ? SETTLE_CYCLES : WIN_CYCLES;
  localparam int unsigned CNT_W       = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;
  localparam int unsigned WIN_LAST    = WIN_CYCLES - 1;
  localparam longint      LIM         = longint'(TURN_MARGIN) * longint'(WIN_CYCLES);
  localparam logic [THETA_W-1:0] THETA_MIN  = {1'b1, {MAG_W{1'b0}}};
  localparam logic [MAG_W-1:0]   THRESH_MAG = MAG_W'(THETA_THRESH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_WINDOW = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [1:0]                exp_dir_q, exp_dir_d;
  logic [MAG_W-1:0]          max_q, max_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      pass_q, pass_d;
  logic                      theta_ok_q, theta_ok_d;
  logic                      dir_ok_q, dir_ok_d;
  logic [1:0]                dir_seen_q, dir_seen_d;
  logic [MAG_W-1:0]          theta_max_abs_q, theta_max_abs_d;
  logic [7:0]                fail_cnt_q, fail_cnt_d;

  logic [MAG_W-1:0]          theta_abs;
  logic [MAG_W-1:0]          max_nxt;
  logic signed [DIFF_W-1:0]  diff;
  logic signed [ACC_W-1:0]   acc_nxt;
  logic [1:0]                dir_nxt;
  logic                      tok_nxt;
  logic                      dok_nxt;

  // Per-sample arithmetic; the most-negative angle saturates instead of wrapping.
  always_comb begin
    if (theta_platform == THETA_MIN) begin
      theta_abs = '1;
    end else if (theta_platform[THETA_W-1]) begin
      theta_abs = MAG_W'(-theta_platform);
    end else begin
      theta_abs = MAG_W'(theta_platform);
    end
    max_nxt = (theta_abs > max_q) ? theta_abs : max_q;
    diff    = DIFF_W'(omega_lft) - DIFF_W'(omega_rght);
    acc_nxt = acc_q + ACC_W'(diff);
    dir_nxt = 2'b00;
    if (longint'(acc_nxt) > LIM) begin
      dir_nxt = 2'b01;
    end else if (longint'(acc_nxt) < -LIM) begin
      dir_nxt = 2'b10;
    end
    tok_nxt = (max_nxt <= THRESH_MAG);
    dok_nxt = (exp_dir_q == 2'b11) || (dir_nxt == exp_dir_q);
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    exp_dir_d       = exp_dir_q;
    max_d           = max_q;
    acc_d           = acc_q;
    done_d          = 1'b0;
    pass_d          = pass_q;
    theta_ok_d      = theta_ok_q;
    dir_ok_d        = dir_ok_q;
    dir_seen_d      = dir_seen_q;
    theta_max_abs_d = theta_max_abs_q;
    fail_cnt_d      = fail_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (!abort && start) begin
          exp_dir_d = expect_dir;
          max_d     = '0;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = (SETTLE_CYCLES == 0) ? S_WINDOW : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(SETTLE_LAST)) begin
          cnt_d   = '0;
          state_d = S_WINDOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WINDOW: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          max_d = max_nxt;
          acc_d = acc_nxt;
          if (cnt_q == CNT_W'(WIN_LAST)) begin
            // Results are graded from the final sample folded in on this same edge.
            state_d         = S_DONE;
            done_d          = 1'b1;
            pass_d          = tok_nxt && dok_nxt;
            theta_ok_d      = tok_nxt;
            dir_ok_d        = dok_nxt;
            dir_seen_d      = dir_nxt;
            theta_max_abs_d = max_nxt;
            if (!(tok_nxt && dok_nxt) && (fail_cnt_q != 8'hFF)) begin
              fail_cnt_d = fail_cnt_q + 8'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_SETTLE) || (state_d == S_WINDOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      exp_dir_q       <= '0;
      max_q           <= '0;
      acc_q           <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      theta_ok_q      <= 1'b0;
      dir_ok_q        <= 1'b0;
      dir_seen_q      <= '0;
      theta_max_abs_q <= '0;
      fail_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      exp_dir_q       <= exp_dir_d;
      max_q           <= max_d;
      acc_q           <= acc_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      theta_ok_q      <= theta_ok_d;
      dir_ok_q        <= dir_ok_d;
      dir_seen_q      <= dir_seen_d;
      theta_max_abs_q <= theta_max_abs_d;
      fail_cnt_q      <= fail_cnt_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign theta_ok      = theta_ok_q;
  assign dir_ok        = dir_ok_q;
  assign dir_seen      = dir_seen_q;
  assign theta_max_abs = theta_max_abs_q;
  assign fail_cnt      = fail_cnt_q;

endmodule

// File: doc/segway_motion_monitor.md
# segway_motion_monitor

Parametrised, synthesizable run-time checker for the Segway balance/steering loop. On a start pulse it waits a settle interval, then samples platform angle and both wheel speeds every clock for a window, and reports whether the platform stayed level and whether the wheel-speed difference matched the expected turn direction. It replaces fixed-delay bench checks with a reusable monitor that can sit beside the physical model in the toplevel benches or inside the DUT for self-test, with width, window, threshold and direction margin as parameters.

## Interface
- THETA_W, 16: width of signed theta_platform
- OMEGA_W, 16: width of signed omega_lft / omega_rght
- SETTLE_CYCLES, 700000: cycles ignored after start (0 allowed)
- WIN_CYCLES, 2000000: sampled cycles per check (>=1)
- THETA_THRESH, 300: max allowed |theta| (unsigned, < 2^(THETA_W-1))
- TURN_MARGIN, 0: per-sample average |lft-rght| margin separating turn from straight
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a check; sampled only in IDLE
- abort  in  1  return to IDLE, no done pulse
- expect_dir  in  2  00 straight, 01 right (lft>rght), 10 left (lft<rght), 11 don't care; latched at start
- theta_platform  in  THETA_W  signed platform angle
- omega_lft  in  OMEGA_W  signed left wheel speed
- omega_rght  in  OMEGA_W  signed right wheel speed
- busy  out  1  high in SETTLE and WINDOW
- done  out  1  one-cycle pulse when results update
- pass  out  1  theta_ok & dir_ok
- theta_ok  out  1  theta_max_abs <= THETA_THRESH
- dir_ok  out  1  dir_seen == latched expect_dir, or expect_dir==11
- dir_seen  out  2  measured direction, same encoding (11 never produced)
- theta_max_abs  out  THETA_W-1  largest |theta| sampled in window
- fail_cnt  out  8  saturating count of completed checks with pass=0

## Operation
- States: IDLE, SETTLE, WINDOW, DONE. Single counter reused for settle and window.
- IDLE: start=1 latches expect_dir, clears max and accumulator; next state SETTLE, or WINDOW if SETTLE_CYCLES==0.
- SETTLE: counts SETTLE_CYCLES edges, inputs ignored, then WINDOW.
- WINDOW: each edge samples inputs: max_abs = max(max_abs, |theta|); acc += (omega_lft - omega_rght) computed at OMEGA_W+1 bits, acc width OMEGA_W+1+clog2(WIN_CYCLES+1), no overflow possible. After WIN_CYCLES samples, go to DONE with results registered.
- |theta| of most-negative value saturates to 2^(THETA_W-1)-1.
- Direction: lim = TURN_MARGIN*WIN_CYCLES; acc > lim -> 01; acc < -lim -> 10; else 00. With TURN_MARGIN=0 straight requires acc==0.
- DONE: done=1 for exactly one cycle; fail_cnt increments if pass=0 (saturates at 255); next state IDLE.
- Results (pass, theta_ok, dir_ok, dir_seen, theta_max_abs) update only on the DONE transition and hold until the next completed check.
- start while busy or in DONE: ignored. abort in SETTLE/WINDOW: IDLE next edge, results and fail_cnt unchanged, no done. abort and start together in IDLE: abort wins.
- Reset (including mid-check): state IDLE; all outputs 0; counters, accumulator, latched expect_dir cleared.

## Timing
- Start edge = edge 0. busy high from after edge 0 through last WINDOW edge.
- Settle edges 1..SETTLE_CYCLES; sampling edges SETTLE_CYCLES+1..SETTLE_CYCLES+WIN_CYCLES (inputs valid at those edges are sampled).
- done and new results visible after edge SETTLE_CYCLES+WIN_CYCLES; done drops after next edge; busy low in same cycle done is high.
- Earliest next start accepted: edge SETTLE_CYCLES+WIN_CYCLES+2 (first IDLE cycle).
- All outputs registered; no combinational input-to-output paths.

## Test plan
- SETTLE=4, WIN=16; theta=100, lft=500, rght=300, expect=01 -> done exactly after edge 20, pass=1, dir_seen=01, theta_max_abs=100, fail_cnt=0.
- Same, theta=+100 except one window sample at -301 -> theta_ok=0, pass=0, theta_max_abs=301, fail_cnt=1; a -301 during settle only -> pass=1.
- lft=rght=400, expect=00 -> dir_seen=00, pass=1; then lft=rght-1 on one sample, expect=00, TURN_MARGIN=0 -> dir_seen=10, pass=0.
- theta=-32768 (THETA_W=16) -> theta_max_abs=32767, no wrap; lft=+32767, rght=-32768 all window -> dir_seen=01, no overflow.
- start mid-check ignored (done timing unchanged); abort at window edge 8 -> busy low next cycle, no done, previous results and fail_cnt held.
- rst_n low mid-WINDOW asynchronously -> all outputs 0 immediately; fail_cnt driven to 255+ failures -> stays 255.
